// File: rtl/aes_enc_pkg.sv
// rtl/aes_enc_pkg.sv - shared types, S-box table and round helpers for the iterative AES encryption core
package aes_enc_pkg;

    localparam int AES_BLK_BITS = 128;

    // Element [15] is byte 0 of the block (bits [127:120]), column-major.
    typedef logic [15:0][7:0] state_t;

    typedef enum logic [2:0] {
        IDLE,
        ARK0,
        SUB,
        MIX,
        DONE
    } fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic int nr_of(input int key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            default: return 14;
        endcase
    endfunction

    // Position of block byte i inside state_t.
    function automatic logic [3:0] bpos(input int i);
        return 4'(15 - i);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[bpos(r + 4 * c)] = s[bpos(r + 4 * ((c + r) % 4))];
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[bpos(4 * c)];
            a1 = s[bpos(4 * c + 1)];
            a2 = s[bpos(4 * c + 2)];
            a3 = s[bpos(4 * c + 3)];
            o[bpos(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[bpos(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[bpos(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[bpos(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_enc_core_param_sbox.sv
// rtl/aes_enc_core_param_sbox.sv - one combinational S-box lane (aes_sbox_lane)
module aes_sbox_lane
    import aes_enc_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_enc_core_param.sv
// rtl/aes_enc_core_param.sv - iterative AES-128/192/256 encryption core, optional round trace via AES_ENC_ROUND_TRACE_EN
module aes_enc_core_param
    import aes_enc_pkg::*;
#(
    parameter int KEY_BITS = 256,
    parameter int N_SBOX   = 4
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AES_BLK_BITS-1:0] in_data,
    output logic [3:0]              rk_idx,
    input  logic [AES_BLK_BITS-1:0] rk_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AES_BLK_BITS-1:0] out_data
`ifdef AES_ENC_ROUND_TRACE_EN
    ,
    output logic                    dbg_round_stb,
    output logic [AES_BLK_BITS-1:0] dbg_state
`endif
);

    localparam int         NR         = nr_of(KEY_BITS);
    localparam int         S          = 16 / N_SBOX;
    localparam int         LANE_SHIFT = $clog2(N_SBOX);
    localparam logic [3:0] NR4        = 4'(NR);
    localparam logic [3:0] S_LAST     = 4'(S - 1);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_enc_core_param: KEY_BITS must be 128, 192 or 256");
    end
    if (!(N_SBOX == 1 || N_SBOX == 2 || N_SBOX == 4 || N_SBOX == 8 || N_SBOX == 16)) begin : g_bad_n_sbox
        $error("aes_enc_core_param: N_SBOX must be 1, 2, 4, 8 or 16");
    end

    fsm_t                    r_fsm;
    state_t                  r_state;
    logic [3:0]              r_round;
    logic [3:0]              r_byte_cnt;
    logic                    r_out_valid;
    logic [AES_BLK_BITS-1:0] r_out_data;

    fsm_t                    w_fsm_nxt;
    state_t                  w_state_nxt;
    logic [3:0]              w_round_nxt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_out_valid_nxt;
    logic [AES_BLK_BITS-1:0] w_out_data_nxt;
    logic                    w_in_ready;
    logic [3:0]              w_rk_idx;
    logic                    w_upd;
    state_t                  w_sub_state;
    state_t                  w_sr;
    state_t                  w_mc;

    logic [3:0]              w_lane_idx [N_SBOX];
    logic [7:0]              w_sb_in    [N_SBOX];
    logic [7:0]              w_sb_out   [N_SBOX];

    // Lane j substitutes block byte k*N_SBOX + j; ~idx maps a block byte index to its state_t slot.
    for (genvar j = 0; j < N_SBOX; j++) begin : g_lane
        assign w_lane_idx[j] = (r_byte_cnt << LANE_SHIFT) + 4'(j);
        assign w_sb_in[j]    = r_state[~w_lane_idx[j]];
        aes_sbox_lane u_lane (
            .i_byte (w_sb_in[j]),
            .o_byte (w_sb_out[j])
        );
    end

    // Next-state, datapath and handshake decode.
    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_state_nxt     = r_state;
        w_round_nxt     = r_round;
        w_cnt_nxt       = r_byte_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_in_ready      = 1'b0;
        w_rk_idx        = 4'd0;
        w_upd           = 1'b0;

        w_sub_state = r_state;
        for (int j = 0; j < N_SBOX; j++) begin
            w_sub_state[~w_lane_idx[j]] = w_sb_out[j];
        end
        w_sr = shift_rows(r_state);
        w_mc = mix_columns(w_sr);

        case (r_fsm)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = state_t'(in_data);
                    w_fsm_nxt   = ARK0;
                end
            end
            ARK0: begin
                w_state_nxt = r_state ^ rk_data;
                w_round_nxt = 4'd1;
                w_cnt_nxt   = 4'd0;
                w_upd       = 1'b1;
                w_fsm_nxt   = SUB;
            end
            SUB: begin
                w_state_nxt = w_sub_state;
                if (r_byte_cnt == S_LAST) begin
                    w_cnt_nxt = 4'd0;
                    w_fsm_nxt = MIX;
                end else begin
                    w_cnt_nxt = r_byte_cnt + 4'd1;
                end
            end
            MIX: begin
                w_rk_idx = r_round;
                w_upd    = 1'b1;
                if (r_round < NR4) begin
                    w_state_nxt = w_mc ^ rk_data;
                    w_round_nxt = r_round + 4'd1;
                    w_fsm_nxt   = SUB;
                end else begin
                    // Final round has no MixColumns; round stays saturated at Nr.
                    w_state_nxt     = w_sr ^ rk_data;
                    w_out_data_nxt  = w_sr ^ rk_data;
                    w_out_valid_nxt = 1'b1;
                    w_fsm_nxt       = DONE;
                end
            end
            DONE: begin
                // A new block may be taken in the same cycle the result is consumed.
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (in_valid) begin
                        w_state_nxt = state_t'(in_data);
                        w_fsm_nxt   = ARK0;
                    end else begin
                        w_fsm_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

    // Core state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_round     <= 4'd0;
            r_byte_cnt  <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_round     <= w_round_nxt;
            r_byte_cnt  <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign in_ready  = w_in_ready & ~reset;
    assign rk_idx    = w_rk_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef AES_ENC_ROUND_TRACE_EN
    logic                    r_dbg_stb;
    logic [AES_BLK_BITS-1:0] r_dbg_state;

    // Snapshot the state written by each ARK0/MIX step, strobed for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_stb   <= 1'b0;
            r_dbg_state <= '0;
        end else begin
            r_dbg_stb <= w_upd;
            if (w_upd) begin
                r_dbg_state <= w_state_nxt;
            end
        end
    end

    assign dbg_round_stb = r_dbg_stb;
    assign dbg_state     = r_dbg_state;
`endif

endmodule

// File: tb/tb_aes_enc_core_param.sv
// tb/tb_aes_enc_core_param.sv - self-checking bench for aes_enc_core_param against a byte-level AES reference
module tb_aes_enc_core_param;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [ND-1:0] in_valid;
    logic [ND-1:0] in_ready;
    logic [ND-1:0] out_valid;
    logic          out_ready;
    logic [127:0]  in_data;
    logic [3:0]    rk_idx   [ND];
    logic [127:0]  rk_data  [ND];
    logic [127:0]  out_data [ND];
    logic [127:0]  rom      [ND][16];
    logic [7:0]    sb       [256];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < ND; g++) begin : g_rom
        assign rk_data[g] = rom[g][rk_idx[g]];
    end

`ifdef AES_ENC_ROUND_TRACE_EN
    logic         dbg_stb;
    logic [127:0] dbg_state;
    int           tr_cnt = 0;
    logic [127:0] tr_log [64];
    always @(posedge clk) begin
        if (dbg_stb) begin
            if (tr_cnt < 64) tr_log[tr_cnt] <= dbg_state;
            tr_cnt <= tr_cnt + 1;
        end
    end
`endif

    aes_enc_core_param #(.KEY_BITS(256), .N_SBOX(4)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data),
        .rk_idx    (rk_idx[0]),
        .rk_data   (rk_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready),
        .out_data  (out_data[0])
`ifdef AES_ENC_ROUND_TRACE_EN
        ,
        .dbg_round_stb (dbg_stb),
        .dbg_state     (dbg_state)
`endif
    );

    aes_enc_core_param #(.KEY_BITS(128), .N_SBOX(16)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data),
        .rk_idx    (rk_idx[1]),
        .rk_data   (rk_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready),
        .out_data  (out_data[1])
    );

    aes_enc_core_param #(.KEY_BITS(192), .N_SBOX(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[2]),
        .in_ready  (in_ready[2]),
        .in_data   (in_data),
        .rk_idx    (rk_idx[2]),
        .rk_data   (rk_data[2]),
        .out_valid (out_valid[2]),
        .out_ready (out_ready),
        .out_data  (out_data[2])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic int key_bits_of(input logic [1:0] d);
        return (d == 2'd0) ? 256 : (d == 2'd1) ? 128 : 192;
    endfunction

    // Nr*(S+1)+2 with S = 16/N_SBOX: 14*5+2, 10*2+2, 12*9+2.
    function automatic int lat_of(input logic [1:0] d);
        return (d == 2'd0) ? 72 : (d == 2'd1) ? 22 : 110;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Key expansion into the round-key ROM of one DUT; key is left-aligned.
    task automatic load_key(input logic [1:0] d, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int          nk;
        int          nr;
        nk = key_bits_of(d) / 32;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = w[i - 1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i - nk] ^ temp;
        end
        for (int r = 0; r <= nr; r++) rom[d][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] aes_ref(input logic [1:0] d, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        int           nr;
        nr = key_bits_of(d) / 32 + 6;
        rk = rom[d][0];
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[127 - 8 * i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4 * c] = s[row + 4 * ((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end else begin
                    for (int row = 0; row < 4; row++) s[row + 4 * c] = t[row + 4 * c];
                end
            end
            rk = rom[d][r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // Offer one block, then count cycles from the accept edge (counted as 1) to out_valid.
    task automatic send_and_wait(input logic [1:0] d, input logic [127:0] pt,
                                 input logic [127:0] exp_ct, input string tag);
        int n;
        int lat;
        in_data     = pt;
        in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, 128'(in_ready[d]), 128'(1));
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 1;
        while (!out_valid[d] && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(lat_of(d)));
        chk({tag, "_ct"}, out_data[d], exp_ct);
    endtask

    task automatic drain(input logic [1:0] d, input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ov_drop"}, 128'(out_valid[d]), 128'(0));
        out_ready = 1'b0;
    endtask

    localparam logic [127:0] C_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] C1_KEY  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [7:0]   inv;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] pt2;
        logic [127:0] e1;
        logic [127:0] e2;
        int           n;
        int           lat;
`ifdef AES_ENC_ROUND_TRACE_EN
        int           tr_base;
`endif

        // S-box from GF(2^8) inverse plus affine map.
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        chk("rst_in_ready_during", 128'(in_ready[0]), 128'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_in_ready", 128'(in_ready[d]), 128'(0));
            chk("rst_out_valid", 128'(out_valid[d]), 128'(0));
            chk("rst_out_data", out_data[d], 128'(0));
            chk("rst_rk_idx", 128'(rk_idx[d]), 128'(0));
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) chk("post_rst_in_ready", 128'(in_ready[d]), 128'(1));

        // FIPS-197 C.3 on the 256-bit core.
        load_key(2'd0, C3_KEY);
`ifdef AES_ENC_ROUND_TRACE_EN
        tr_base = tr_cnt;
`endif
        send_and_wait(2'd0, C_PT, C3_CT, "c3");
        chk("c3_model", out_data[0], aes_ref(2'd0, C_PT));
        drain(2'd0, "c3");
`ifdef AES_ENC_ROUND_TRACE_EN
        chk("trace_pulses", 128'(tr_cnt - tr_base), 128'(15));
        chk("trace_round1", tr_log[tr_base + 1], 128'h4f63760643e0aa85efa7213201a4e705);
`endif

        // FIPS-197 C.1 on the 128-bit core.
        load_key(2'd1, C1_KEY);
        send_and_wait(2'd1, C_PT, C1_CT, "c1");
        drain(2'd1, "c1");

        // Random keys and blocks on all three configurations.
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < ND; d++) begin
                key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                pt  = {$urandom, $urandom, $urandom, $urandom};
                load_key(2'(d), key);
                send_and_wait(2'(d), pt, aes_ref(2'(d), pt), "rand");
                drain(2'(d), "rand");
            end
        end

        // Back-to-back: second block taken in the DONE cycle of the first.
        load_key(2'd0, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        pt  = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        e1  = aes_ref(2'd0, pt);
        e2  = aes_ref(2'd0, pt2);
        out_ready   = 1'b1;
        in_data     = pt;
        in_valid[0] = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_data = pt2;
        lat = 1;
        while (!out_valid[0] && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat1", 128'(lat), 128'(72));
        chk("b2b_ct1", out_data[0], e1);
        chk("b2b_in_ready_done", 128'(in_ready[0]), 128'(1));
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("b2b_ov_drop", 128'(out_valid[0]), 128'(0));
        chk("b2b_busy", 128'(in_ready[0]), 128'(0));
        lat = 1;
        while (!out_valid[0] && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat2", 128'(lat), 128'(72));
        chk("b2b_ct2", out_data[0], e2);
        @(posedge clk); #1;
        chk("b2b_ov_drop2", 128'(out_valid[0]), 128'(0));
        out_ready = 1'b0;

        // Backpressure: result holds and a new block is refused.
        load_key(2'd1, {$urandom, $urandom, $urandom, $urandom, 128'h0});
        pt = {$urandom, $urandom, $urandom, $urandom};
        e1 = aes_ref(2'd1, pt);
        send_and_wait(2'd1, pt, e1, "bp");
        in_data     = ~pt;
        in_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", out_data[1], e1);
            chk("bp_hold_valid", 128'(out_valid[1]), 128'(1));
            chk("bp_in_ready", 128'(in_ready[1]), 128'(0));
        end
        in_valid[1] = 1'b0;
        drain(2'd1, "bp");
        chk("bp_no_accept", 128'(in_ready[1]), 128'(1));

        // Reset during round 5, then a clean C.3 run.
        load_key(2'd0, C3_KEY);
        in_data     = C_PT;
        in_valid[0] = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (23) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 128'(in_ready[0]), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ov", 128'(out_valid[0]), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(0));
        reset = 1'b0;
        #1;
        chk("mid_idle", 128'(in_ready[0]), 128'(1));
        chk("mid_out_data", out_data[0], 128'(0));
        send_and_wait(2'd0, C_PT, C3_CT, "mid_c3");
        drain(2'd0, "mid_c3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
